// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration count and a magnitude helper.
package mul_div_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: shift-add multiply or restoring divide step.
// Accumulator layout: multiply {partial_sum, multiplier}; divide {remainder, quotient}.
module mul_div_step (
  input  logic        mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic        q_bit;
  logic [31:0] rem_new;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    div_shift = acc[63:31];
    div_trial = div_shift - {1'b0, operand};
    // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
    q_bit     = ~div_trial[32];
    rem_new   = q_bit ? div_trial[31:0] : div_shift[31:0];
    if (mode) begin
      acc_next = {rem_new, acc[30:0], q_bit};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Define MUL_DIV_FAST_MUL_EN for a single-cycle multiplier (divide unchanged).
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic        Cancel,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic               op_div;
  logic [31:0]        mag1;
  logic [31:0]        mag2;
  logic [63:0]        step_acc;
  logic [63:0]        prod_fix;
  logic [31:0]        rem_fix;
  logic [31:0]        quo_fix;

  mul_div_step u_step (
    .mode     (is_div_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc)
  );

  always_comb begin
    op_signed = (Op == OP_MULT) || (Op == OP_DIV);
    op_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    mag1      = mag32(In1, op_signed);
    mag2      = mag32(In2, op_signed);
    prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
    rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d   = In1;
            done_d = 1'b1;
          end else if (Op == OP_MTLO) begin
            lo_d   = In1;
            done_d = 1'b1;
`ifdef MUL_DIV_FAST_MUL_EN
          end else if (Op == OP_MULT || Op == OP_MULTU) begin
            {hi_d, lo_d} = {{32{op_signed & In1[31]}}, In1} * {{32{op_signed & In2[31]}}, In2};
            done_d       = 1'b1;
          end else if (op_div) begin
`else
          end else if (Op <= OP_DIVU) begin
`endif
            // Divide keeps the divisor as operand; multiply keeps the multiplicand.
            acc_d     = {32'h0, op_div ? mag1 : mag2};
            opnd_d    = op_div ? mag2 : mag1;
            is_div_d  = op_div;
            neg_d     = op_signed && (In1[31] ^ In2[31]);
            neg_rem_d = op_signed && In1[31];
            div0_d    = (In2 == 32'h0);
            cnt_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? 32'hFFFF_FFFF : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything, including a same-cycle Start or FIX write.
    if (Cancel) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the EX stage, beside the ALU. It takes the same forwarded operand pair the ALU sees and owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU over multiple cycles and raises Busy so the hazard unit stalls the pipe. It also supplies Hi/Lo to the EX result mux for MFHI/MFLO, which means it sits directly downstream of the operand forwarding muxes and upstream of the EX/MEM register.

## Interface
Parameters:
- ITER, 32: divide iteration count, and multiply iteration count when the fast multiplier is compiled out. Fixed at 32; not user-tunable.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- Start, input, 1: issue strobe, qualified by Op. Sampled only when Busy=0.
- Op, input, 3: operation code, from the shared package.
  - MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5.
  - Codes 6 and 7 are reserved.
- Cancel, input, 1: pipeline flush. Aborts any operation in flight.
- In1, input, 32: rs operand (dividend / multiplicand / MTHI/MTLO source).
- In2, input, 32: rt operand (divisor / multiplier).
- Busy, output, 1: operation in flight. Hazard unit stalls MFHI/MFLO and any new mul/div.
- Done, output, 1: one-cycle pulse; the new Hi/Lo is visible in the same cycle.
- Hi, output, 32: HI register.
- Lo, output, 32: LO register.

## Operation
- State machine: IDLE, CALC, FIX. Busy = (state != IDLE).
- IDLE
  - Start with MULT/MULTU/DIV/DIVU: latch |In1| and |In2| (magnitudes for signed ops, raw values for unsigned ops), latch the result signs, clear the counter, go to CALC.
  - Start with MTHI/MTLO: write In1 to Hi or Lo, pulse Done next cycle, stay in IDLE.
  - Reserved Op: ignored; no Done.
- CALC
  - Each edge performs one step:
    - multiply: shift-add, 64-bit accumulator.
    - divide: restoring shift-subtract, 1 quotient bit per edge.
  - Counter increments each edge; after the 32nd step, go to FIX.
- FIX
  - Apply signs:
    - product: negate the 64-bit product if the operand signs differ.
    - quotient: negated if sign(In1) ^ sign(In2).
    - remainder: takes the sign of In1.
  - Write {Hi,Lo}: product goes to {Hi,Lo}; remainder goes to Hi, quotient to Lo.
  - Go to IDLE and pulse Done.
- Divide by zero (In2=0, DIV or DIVU): Hi=In1 (original value), Lo=32'hFFFF_FFFF, with normal latency.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: Lo=0x8000_0000, Hi=0.
- Start while Busy=1: ignored. The hazard unit must not issue one; the bench checks that it is dropped.
- Cancel in any state: go to IDLE next edge, no Done, Hi/Lo unchanged.
  - Cancel and Start in the same cycle: Cancel wins, so no operation starts and no MTHI/MTLO write occurs.
- Reset (asynchronous, any state): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0.

## Timing
- Edge k samples Start.
- MTHI/MTLO: register written at edge k; Done=1 in cycle k+1; Busy never asserted.
- Iterative mul/div:
  - Busy=1 from after edge k through after edge k+32 (33 cycles).
  - CALC steps occur at edges k+1 to k+32.
  - FIX write occurs at edge k+33; after it, Done=1 and Busy=0.
- Back-to-back: a new Start is accepted in the Done cycle.
- Hi/Lo are plain register outputs with no combinational path from In1/In2.

## Configuration
- MUL_DIV_FAST_MUL_EN defined:
  - MULT/MULTU are computed with a single-cycle 64-bit multiply.
  - {Hi,Lo} is written at edge k; Done=1 in cycle k+1; Busy is never asserted for multiply.
  - Divide is unchanged.
- Not defined: multiply uses the 33-cycle iterative path above.

## Structure
- Package mul_div_pkg: Op codes, state encoding, ITER constant.
- One sub-module, mul_div_step: combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator, next partial remainder/quotient.
  - The top level holds the registers, counter, FSM and sign fix.

## Test plan
- DIVU 100/7: Busy for 33 cycles, then Done with Hi=2, Lo=14.
- DIV -7/2 (0xFFFF_FFF9 / 2): Hi=0xFFFF_FFFF, Lo=0xFFFF_FFFD. Then DIV 0x8000_0000 / 0xFFFF_FFFF: Hi=0, Lo=0x8000_0000.
- MULT 0xFFFF_FFFF × 0xFFFF_FFFF: Hi=0, Lo=1. Then MULTU of the same operands: Hi=0xFFFF_FFFE, Lo=1. Check latency in both macro settings.
- DIVU 5/0: Hi=5, Lo=0xFFFF_FFFF. Then MTHI 0x1234 followed next cycle by MTLO 0x5678: Hi=0x1234, Lo=0x5678, one Done pulse each.
- DIV started, Cancel asserted at CALC step 10: Busy drops next edge, no Done, Hi/Lo keep their prior values. A Start issued during Busy produces no effect.
- reset asserted mid-CALC (asynchronously, between clock edges): Busy, Done, Hi and Lo are 0 immediately. After release, a new MULTU 3×4 gives Lo=12.
